// File: rtl/mem_lane_pkg.sv
// Shared types for the byte-lane data memory: size codes, controller states, lane row mapping.
package mem_lane_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  // Lanes below the start offset belong to the following row; callers truncate to row width.
  function automatic logic [31:0] lane_row(input logic [31:0] addr, input int unsigned lane,
                                           input int unsigned lw);
    logic [31:0] off;
    off      = addr & ((32'd1 << lw) - 32'd1);
    lane_row = (addr >> lw) + {31'b0, (32'(lane) < off)};
  endfunction

endpackage

// File: rtl/mem_lane_bank.sv
// One byte-wide synchronous RAM bank: write on we, read address registered on en.
module mem_lane_bank #(
  parameter int ROW_W = 14
) (
  input  logic             clock,
  input  logic             en,
  input  logic             we,
  input  logic [ROW_W-1:0] addr,
  input  logic [7:0]       wdat,
  output logic [7:0]       rdat
);

  logic [7:0]       mem [2**ROW_W];
  logic [ROW_W-1:0] addr_q;

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdat;
    if (en) addr_q <= addr;
  end

  assign rdat = mem[addr_q];

endmodule

// File: rtl/mem_lane_ctrl.sv
// Big-endian byte-lane memory controller; stores/errors respond 1 cycle after accept, loads 2.
// Response held until rsp_ready. MISALIGN_TRAP_EN turns misaligned accesses into errors.
module mem_lane_ctrl
  import mem_lane_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ADDR_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [8*LANES-1:0]   req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*LANES-1:0]   rsp_rdata,
  output logic                 rsp_err
);

  localparam int LW    = $clog2(LANES);
  localparam int ROW_W = ADDR_W - LW;
  localparam int DW    = 8 * LANES;

  state_t           state, state_nx;
  logic             accept;
  logic             req_err;
  logic [3:0]       req_n;
  logic [LW-1:0]    req_off;
  logic [LW-1:0]    idx;
  logic [3:0]       ld_n;
  logic [LW-1:0]    ld_off;
  logic             ld_sgn;
  logic [DW-1:0]    ld_val, ld_ext;
  logic             ld_sbit;
  logic [LW-1:0]    rd_lane;

  logic [ROW_W-1:0] bank_row  [LANES];
  logic             bank_we   [LANES];
  logic [7:0]       bank_wdat [LANES];
  logic [7:0]       bank_rdat [LANES];

  assign req_off = req_addr[LW-1:0];

  always_comb begin
    case (req_size)
      SZ_BYTE: req_n = 4'd1;
      SZ_HALF: req_n = 4'd2;
      SZ_WORD: req_n = 4'd4;
      default: req_n = 4'd0;
    endcase
    req_err = (req_size == SZ_RSVD) || (int'(req_n) > LANES);
`ifdef MISALIGN_TRAP_EN
    if ((req_addr & (ADDR_W'(req_n) - ADDR_W'(1))) != '0) req_err = 1'b1;
`endif
  end

  always_comb begin
    state_nx  = state;
    req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    accept    = req_valid && req_ready;
    case (state)
      READ:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = state;
    endcase
    if (accept) state_nx = (req_err || req_we) ? RESP : READ;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign rsp_valid = (state == RESP);

  // idx is the byte position within the access that lands in lane l (big-endian).
  always_comb begin
    idx = '0;
    for (int l = 0; l < LANES; l++) begin
      idx          = LW'(l) - req_off;
      bank_row[l]  = ROW_W'(lane_row(32'(req_addr), l, LW));
      bank_we[l]   = accept && req_we && !req_err && ({1'b0, idx} < req_n);
      bank_wdat[l] = ({1'b0, idx} < req_n) ?
                     8'(req_wdata >> (8 * (int'(req_n) - 1 - int'(idx)))) : 8'h00;
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_bank
      mem_lane_bank #(.ROW_W(ROW_W)) u_bank (
        .clock (clock),
        .en    (accept),
        .we    (bank_we[g]),
        .addr  (bank_row[g]),
        .wdat  (bank_wdat[g]),
        .rdat  (bank_rdat[g])
      );
    end
  endgenerate

  always_comb begin
    ld_val  = '0;
    rd_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_lane = ld_off + LW'(i);
      if (i < int'(ld_n))
        ld_val = ld_val | (DW'(bank_rdat[rd_lane]) << (8 * (int'(ld_n) - 1 - i)));
    end
    ld_sbit = (ld_n != 4'd0) ? ld_val[8*int'(ld_n)-1] : 1'b0;
    ld_ext  = ld_val;
    if (ld_sgn && ld_sbit) ld_ext = ld_val | ({DW{1'b1}} << (8 * int'(ld_n)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ld_n      <= '0;
      ld_off    <= '0;
      ld_sgn    <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= '0;
      rsp_err   <= req_err;
      ld_n      <= req_n;
      ld_off    <= req_off;
      ld_sgn    <= req_signed;
    end else if (state == READ) begin
      rsp_rdata <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Directed bench for mem_lane_ctrl (default build, misaligned accesses performed).
module tb_mem_lane_ctrl;
  import mem_lane_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = SZ_BYTE;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  mem_lane_ctrl #(.LANES(4), .ADDR_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    if (!req_ready) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clock); lat++; end
    if (!rsp_valid) chk("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  task automatic store(input logic [1:0] size, input logic [15:0] addr, input logic [31:0] wdata);
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, size, 1'b0, addr, wdata, rd, er, lat);
    if (er !== 1'b0) chk("store_err", {31'b0, er}, 32'd0);
  endtask

  task automatic load_chk(input string tag, input logic [1:0] size, input logic sgn,
                          input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, size, sgn, addr, 32'd0, rd, er, lat);
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] held;
    logic        er;
    int          lat;

    repeat (2) @(negedge clock);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    reset = 1'b0;
    #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);

    // 1: word store/load with latency
    do_req(1'b1, SZ_WORD, 1'b0, 16'h0010, 32'hA1B2C3D4, rd, er, lat);
    chk("st_word_lat", lat, 32'd1);
    chk("st_word_rdata", rd, 32'd0);
    do_req(1'b0, SZ_WORD, 1'b0, 16'h0010, 32'd0, rd, er, lat);
    chk("ld_word", rd, 32'hA1B2C3D4);
    chk("ld_word_lat", lat, 32'd2);
    chk("ld_word_err", {31'b0, er}, 32'd0);

    // 2: byte store and extension
    store(SZ_BYTE, 16'h0013, 32'h00000080);
    load_chk("ld_byte_s", SZ_BYTE, 1'b1, 16'h0013, 32'hFFFFFF80);
    load_chk("ld_byte_u", SZ_BYTE, 1'b0, 16'h0013, 32'h00000080);
    load_chk("ld_word_after_byte", SZ_WORD, 1'b0, 16'h0010, 32'hA1B2C380);
    load_chk("ld_half_s", SZ_HALF, 1'b1, 16'h0010, 32'hFFFFA1B2);
    load_chk("ld_half_u", SZ_HALF, 1'b0, 16'h0012, 32'h0000C380);

    // 3: half store straddling a row
    store(SZ_WORD, 16'h0014, 32'h00000000);
    store(SZ_WORD, 16'h0018, 32'h00000000);
    store(SZ_HALF, 16'h0017, 32'h0000BEEF);
    load_chk("straddle_17", SZ_BYTE, 1'b0, 16'h0017, 32'h000000BE);
    load_chk("straddle_18", SZ_BYTE, 1'b0, 16'h0018, 32'h000000EF);
    load_chk("straddle_w14", SZ_WORD, 1'b0, 16'h0014, 32'h000000BE);
    load_chk("straddle_w16", SZ_WORD, 1'b0, 16'h0016, 32'h00BEEF00);
    load_chk("straddle_w18", SZ_WORD, 1'b0, 16'h0018, 32'hEF000000);

    // 4: wrap at top of memory
    store(SZ_WORD, 16'hFFFE, 32'h11223344);
    load_chk("wrap_fffe", SZ_BYTE, 1'b0, 16'hFFFE, 32'h00000011);
    load_chk("wrap_ffff", SZ_BYTE, 1'b0, 16'hFFFF, 32'h00000022);
    load_chk("wrap_0000", SZ_BYTE, 1'b0, 16'h0000, 32'h00000033);
    load_chk("wrap_0001", SZ_BYTE, 1'b0, 16'h0001, 32'h00000044);
    load_chk("wrap_word", SZ_WORD, 1'b0, 16'hFFFE, 32'h11223344);

    // 5: backpressure then same-cycle accept of queued request
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 16'h0010; rsp_ready = 1'b0;
    @(negedge clock);
    req_size = SZ_BYTE; req_addr = 16'h0013;
    @(negedge clock);
    held = rsp_rdata;
    chk("bp_first_rdata", held, 32'hA1B2C380);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, held);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    chk("b2b_read_state", {31'b0, rsp_valid}, 32'd0);
    @(negedge clock);
    chk("b2b_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_rdata", rsp_rdata, 32'h00000080);

    // 6: reset during READ, then error request
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 16'h0010;
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_read_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_read_rdata", rsp_rdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_rel_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rel_valid", {31'b0, rsp_valid}, 32'd0);
    load_chk("rst_preserved", SZ_WORD, 1'b0, 16'h0010, 32'hA1B2C380);
    do_req(1'b1, SZ_RSVD, 1'b0, 16'h0010, 32'hFFFFFFFF, rd, er, lat);
    chk("rsvd_err", {31'b0, er}, 32'd1);
    chk("rsvd_rdata", rd, 32'd0);
    chk("rsvd_lat", lat, 32'd1);
    load_chk("rsvd_no_write", SZ_WORD, 1'b0, 16'h0010, 32'hA1B2C380);
    do_req(1'b0, SZ_RSVD, 1'b1, 16'h0010, 32'd0, rd, er, lat);
    chk("rsvd_ld_err", {31'b0, er}, 32'd1);
    chk("rsvd_ld_rdata", rd, 32'd0);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
